resp_id_restore: RTL

Response-path companion to the single-entry ID generator in the AXI ID remapper. It accepts narrow-ID response beats (B or R) from the downstream slave, looks up the original wide ID through the generator's table port, and forwards each beat upstream with the wide ID through a 2-entry elastic buffer. On the last beat of each response it releases the table entry. It also flags orphan and ID-mismatch responses.

---
 rtl/resp_id_restore.sv | 138 +++++++++++++
 1 files changed

// File: rtl/resp_id_restore.sv
// Restores the wide upstream ID on B/R response beats and flags orphan or mismatched-ID responses.
// Latency: a beat accepted at edge N is presented on m_* after edge N (buffer is 2 entries, FIFO order).
// Backpressure: s_ready_o drops only when both entries are full; it never depends on s_valid_i or on errors.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   s_valid_i/s_ready_o     downstream beat handshake; s_id_i, s_last_i, s_payload_i beat fields
//   lookup_id_o/lookup_id_i narrow ID sent to the ID generator and the wide ID it returns
//   gen_empty_i             generator holds no outstanding ID
//   release_id_o            frees the generator entry on the last beat of a response
//   m_valid_o/m_ready_i     upstream beat handshake; m_id_o, m_last_o, m_payload_o beat fields
//   err_o                   sticky protocol error (orphan response or ID change inside a burst)
//   resp_count_o            completed-response count
//
// Optional feature: define RESP_ID_RESTORE_STATS_EN to build the saturating response
// counter; otherwise resp_count_o is tied to zero.
module resp_id_restore #(
    parameter int ID_WIDTH_IN   = 8,
    parameter int ID_WIDTH_OUT  = 6,
    parameter int PAYLOAD_WIDTH = 66
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [ID_WIDTH_OUT-1:0]  s_id_i,
    input  logic                     s_last_i,
    input  logic [PAYLOAD_WIDTH-1:0] s_payload_i,
    output logic [ID_WIDTH_OUT-1:0]  lookup_id_o,
    input  logic [ID_WIDTH_IN-1:0]   lookup_id_i,
    input  logic                     gen_empty_i,
    output logic                     release_id_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [ID_WIDTH_IN-1:0]   m_id_o,
    output logic                     m_last_o,
    output logic [PAYLOAD_WIDTH-1:0] m_payload_o,
    output logic                     err_o,
    output logic [15:0]              resp_count_o
);

    localparam int EW = ID_WIDTH_IN + 1 + PAYLOAD_WIDTH;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [EW-1:0]           mem_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic                    in_burst_q;
    logic [ID_WIDTH_OUT-1:0] burst_id_q;
    logic                    err_q;

    logic          accept;
    logic          pop;
    logic          orphan;
    logic          mismatch;
    logic [EW-1:0] push_dat;
    logic [EW-1:0] head_dat;

    assign s_ready_o   = (state_q != TWO);
    assign m_valid_o   = (state_q != EMPTY);
    assign accept      = s_valid_i & s_ready_o;
    assign pop         = m_valid_o & m_ready_i;
    assign lookup_id_o = s_id_i;

    // A beat is "first" when no burst is open; only first beats may be orphans,
    // only later beats can disagree with the captured burst ID.
    assign orphan   = ~in_burst_q & gen_empty_i;
    assign mismatch = in_burst_q & (s_id_i != burst_id_q);

    // An orphan has no table entry, so it must not free someone else's.
    assign release_id_o = accept & s_last_i & ~orphan;

    assign push_dat    = {lookup_id_i, s_last_i, s_payload_i};
    assign head_dat    = mem_q[rd_ptr_q];
    assign m_id_o      = head_dat[EW-1 -: ID_WIDTH_IN];
    assign m_last_o    = head_dat[PAYLOAD_WIDTH];
    assign m_payload_o = head_dat[PAYLOAD_WIDTH-1:0];
    assign err_o       = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !pop)      state_d = TWO;
                else if (pop && !accept) state_d = EMPTY;
            end
            TWO:   if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            in_burst_q <= 1'b0;
            burst_id_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ~wr_ptr_q;
                in_burst_q      <= ~s_last_i;
                if (!in_burst_q) burst_id_q <= s_id_i;
                if (orphan || mismatch) err_q <= 1'b1;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

`ifdef RESP_ID_RESTORE_STATS_EN
    logic [15:0] resp_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_cnt_q <= '0;
        end else if (pop && m_last_o && (resp_cnt_q != 16'hFFFF)) begin
            resp_cnt_q <= resp_cnt_q + 16'd1;
        end
    end

    assign resp_count_o = resp_cnt_q;
`else
    assign resp_count_o = '0;
`endif

endmodule
